// File: rtl/seq_alu.sv
// seq_alu: registered multicycle ALU with a start/done handshake.
// Single-cycle ops finish one clock after start; MUL (and optionally the
// divider) iterate one bit per clock and finish WORD_SIZE+1 clocks after start.
// Optional feature: define SEQ_ALU_DIVIDE_EN to add DIVU (1100) and REMU (1101)
// as iterative restoring-division ops; otherwise 1100-1111 are illegal.
module seq_alu #(
  parameter int WORD_SIZE = 32,
  parameter int SHAMT_W   = 5,
  parameter int CNT_W     = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [3:0]           ALUOp,
  input  logic [WORD_SIZE-1:0] R2,
  input  logic [WORD_SIZE-1:0] R3,
  output logic                 busy,
  output logic                 done,
  output logic [WORD_SIZE-1:0] R1,
  output logic                 Zero,
  output logic                 Illegal
);

  localparam logic [3:0] OP_MOV  = 4'b0000;
  localparam logic [3:0] OP_NOT  = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_OR   = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_MUL  = 4'b1011;
`ifdef SEQ_ALU_DIVIDE_EN
  localparam logic [3:0] OP_DIVU = 4'b1100;
  localparam logic [3:0] OP_REMU = 4'b1101;
`endif

  localparam logic [CNT_W-1:0]     CNT_LOAD = CNT_W'(WORD_SIZE);
  localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);
  localparam logic [WORD_SIZE-1:0] WORD_Z   = {WORD_SIZE{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_FIN  = 2'b10
  } state_t;

  state_t               state_r;
  logic [CNT_W-1:0]     cnt_r;
  logic [WORD_SIZE-1:0] opa_r;   // MUL: multiplicand; DIV: dividend -> quotient
  logic [WORD_SIZE-1:0] opb_r;   // MUL: multiplier;   DIV: divisor
  logic [WORD_SIZE-1:0] acc_r;   // MUL: partial sum;  DIV: partial remainder
  logic [WORD_SIZE-1:0] r1_r;
  logic                 zero_r;
  logic                 illegal_r;
  logic                 busy_r;
  logic                 done_r;
`ifdef SEQ_ALU_DIVIDE_EN
  logic [3:0]           op_r;
  logic [WORD_SIZE:0]   div_shift_s;
  logic [WORD_SIZE-1:0] div_diff_s;
`endif

  logic [SHAMT_W-1:0]   shamt_s;
  logic                 slt_s;
  logic [WORD_SIZE-1:0] alu_res_s;
  logic                 illegal_s;
  logic                 iter_s;
  logic [WORD_SIZE-1:0] acc_nxt_s;
  logic [WORD_SIZE-1:0] opa_nxt_s;
  logic [WORD_SIZE-1:0] opb_nxt_s;
  logic [WORD_SIZE-1:0] iter_res_s;

  assign shamt_s = R3[SHAMT_W-1:0];
  assign slt_s   = ($signed(R2) < $signed(R3));

  // Decode the requested op: single-cycle result, iterative flag, illegal flag
  always_comb begin
    alu_res_s = WORD_Z;
    illegal_s = 1'b0;
    iter_s    = 1'b0;
    case (ALUOp)
      OP_MOV:  alu_res_s = R2;
      OP_NOT:  alu_res_s = ~R2;
      OP_ADD:  alu_res_s = R2 + R3;
      OP_SUB:  alu_res_s = R2 - R3;
      OP_OR:   alu_res_s = R2 | R3;
      OP_AND:  alu_res_s = R2 & R3;
      OP_XOR:  alu_res_s = R2 ^ R3;
      OP_SLT:  alu_res_s = {{(WORD_SIZE-1){1'b0}}, slt_s};
      OP_SLL:  alu_res_s = R2 << shamt_s;
      OP_SRL:  alu_res_s = R2 >> shamt_s;
      OP_SRA:  alu_res_s = $unsigned($signed(R2) >>> shamt_s);
      OP_MUL:  iter_s    = 1'b1;
`ifdef SEQ_ALU_DIVIDE_EN
      OP_DIVU: iter_s    = 1'b1;
      OP_REMU: iter_s    = 1'b1;
`endif
      default: illegal_s = 1'b1;
    endcase
  end

  // One iteration step of the shift-add multiplier (or restoring divider)
  always_comb begin
    if (opb_r[0]) begin
      acc_nxt_s = acc_r + opa_r;
    end else begin
      acc_nxt_s = acc_r;
    end
    opa_nxt_s  = {opa_r[WORD_SIZE-2:0], 1'b0};
    opb_nxt_s  = {1'b0, opb_r[WORD_SIZE-1:1]};
    iter_res_s = acc_nxt_s;
`ifdef SEQ_ALU_DIVIDE_EN
    // Remainder stays below the divisor, so the shifted value fits WORD_SIZE+1
    // bits and the difference fits WORD_SIZE bits. A zero divisor always
    // "subtracts", giving an all-ones quotient and the dividend as remainder.
    div_shift_s = {acc_r, opa_r[WORD_SIZE-1]};
    div_diff_s  = WORD_SIZE'(div_shift_s - {1'b0, opb_r});
    if ((op_r == OP_DIVU) || (op_r == OP_REMU)) begin
      opb_nxt_s = opb_r;
      if (div_shift_s >= {1'b0, opb_r}) begin
        acc_nxt_s = div_diff_s;
        opa_nxt_s = {opa_r[WORD_SIZE-2:0], 1'b1};
      end else begin
        acc_nxt_s = div_shift_s[WORD_SIZE-1:0];
        opa_nxt_s = {opa_r[WORD_SIZE-2:0], 1'b0};
      end
      if (op_r == OP_DIVU) begin
        iter_res_s = opa_nxt_s;
      end else begin
        iter_res_s = acc_nxt_s;
      end
    end else begin
      iter_res_s = acc_nxt_s;
    end
`endif
  end

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      opa_r     <= WORD_Z;
      opb_r     <= WORD_Z;
      acc_r     <= WORD_Z;
      r1_r      <= WORD_Z;
      zero_r    <= 1'b1;
      illegal_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
`ifdef SEQ_ALU_DIVIDE_EN
      op_r      <= 4'b0000;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            if (iter_s) begin
              opa_r   <= R2;
              opb_r   <= R3;
              acc_r   <= WORD_Z;
              cnt_r   <= CNT_LOAD;
              busy_r  <= 1'b1;
              state_r <= ST_EXEC;
`ifdef SEQ_ALU_DIVIDE_EN
              op_r    <= ALUOp;
`endif
            end else begin
              r1_r      <= alu_res_s;
              zero_r    <= (alu_res_s == WORD_Z);
              illegal_r <= illegal_s;
              done_r    <= 1'b1;
              state_r   <= ST_FIN;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          opa_r <= opa_nxt_s;
          opb_r <= opb_nxt_s;
          acc_r <= acc_nxt_s;
          cnt_r <= cnt_r - CNT_ONE;
          if (cnt_r == CNT_ONE) begin
            r1_r      <= iter_res_s;
            zero_r    <= (iter_res_s == WORD_Z);
            illegal_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b1;
            state_r   <= ST_FIN;
          end else begin
            state_r <= ST_EXEC;
          end
        end
        ST_FIN: begin
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign R1      = r1_r;
  assign Zero    = zero_r;
  assign Illegal = illegal_r;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WORD_SIZE=32): directed vector table,
// hand-written multi-cycle sequences (busy/done timing, ignored starts,
// mid-op reset) and randomized ops checked against an arithmetic model.
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  ALUOp;
  logic [31:0] R2;
  logic [31:0] R3;
  logic        busy;
  logic        done;
  logic [31:0] R1;
  logic        Zero;
  logic        Illegal;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_alu #(.WORD_SIZE(32), .SHAMT_W(5), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .ALUOp(ALUOp), .R2(R2), .R3(R3),
    .busy(busy), .done(done), .R1(R1), .Zero(Zero), .Illegal(Illegal)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic        ez;
    logic        eil;
    int          elat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input logic ez, input logic eil, input int elat);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.exp = exp; v.ez = ez; v.eil = eil; v.elat = elat;
    vecs.push_back(v);
  endtask

  // Issue one op, wait (bounded) for done, return outputs and latency; leaves DUT idle.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic z, output logic il, output int lat);
    @(negedge clk);
    ALUOp = op; R2 = a; R3 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    res = R1; z = Zero; il = Illegal;
    @(posedge clk); #1;
  endtask

  // Behavioural reference built from the operation definitions.
  function automatic void ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] res, output logic il, output int lat);
    int sh;
    logic [63:0] ext;
    sh  = int'(b & 32'd31);
    res = 32'd0; il = 1'b0; lat = 1;
    ext = {{32{a[31]}}, a} >> sh;
    case (op)
      4'd0:  res = a;
      4'd1:  res = ~a;
      4'd2:  res = a + b;
      4'd3:  res = a - b;
      4'd4:  res = a | b;
      4'd5:  res = a & b;
      4'd6:  res = a ^ b;
      4'd7:  res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd8:  res = a << sh;
      4'd9:  res = a >> sh;
      4'd10: res = ext[31:0];
      4'd11: begin res = a * b; lat = 33; end
`ifdef SEQ_ALU_DIVIDE_EN
      4'd12: begin res = (b == 32'd0) ? 32'hFFFFFFFF : a / b; lat = 33; end
      4'd13: begin res = (b == 32'd0) ? a : a % b; lat = 33; end
`endif
      default: begin res = 32'd0; il = 1'b1; end
    endcase
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] res;
    logic z, il;
    int lat;
    logic [31:0] ea, eb, eres;
    logic eil;
    int elat;
    logic [31:0] r1_hold;
    int pulses;

    // Directed table
    add_vec(4'b0011, 32'd3, 32'd5, 32'hFFFFFFFE, 1'b0, 1'b0, 1);
    add_vec(4'b0011, 32'd9, 32'd9, 32'h00000000, 1'b1, 1'b0, 1);
    add_vec(4'b0111, 32'hFFFFFFFF, 32'd1, 32'h00000001, 1'b0, 1'b0, 1);
    add_vec(4'b0111, 32'd1, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1);
    add_vec(4'b0001, 32'd0, 32'd0, 32'hFFFFFFFF, 1'b0, 1'b0, 1);
    add_vec(4'b0000, 32'h12345678, 32'd0, 32'h12345678, 1'b0, 1'b0, 1);
    add_vec(4'b0100, 32'hF0F00000, 32'h00000F0F, 32'hF0F00F0F, 1'b0, 1'b0, 1);
    add_vec(4'b0101, 32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00, 1'b0, 1'b0, 1);
    add_vec(4'b0110, 32'hFFFF0000, 32'hFF00FF00, 32'h00FFFF00, 1'b0, 1'b0, 1);
    add_vec(4'b0010, 32'hFFFFFFFF, 32'd1, 32'h00000000, 1'b1, 1'b0, 1);
    add_vec(4'b1000, 32'h80000001, 32'd4, 32'h00000010, 1'b0, 1'b0, 1);
    add_vec(4'b1010, 32'h80000001, 32'd4, 32'hF8000000, 1'b0, 1'b0, 1);
    add_vec(4'b1001, 32'h80000001, 32'd36, 32'h08000000, 1'b0, 1'b0, 1);
    add_vec(4'b1000, 32'h80000001, 32'd32, 32'h80000001, 1'b0, 1'b0, 1);
    add_vec(4'b1011, 32'h00010001, 32'h00010001, 32'h00020001, 1'b0, 1'b0, 33);
    add_vec(4'b1111, 32'd7, 32'd7, 32'h00000000, 1'b1, 1'b1, 1);
    add_vec(4'b0010, 32'd1, 32'd1, 32'h00000002, 1'b0, 1'b0, 1);
`ifdef SEQ_ALU_DIVIDE_EN
    add_vec(4'b1100, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, 33);
    add_vec(4'b1101, 32'd100, 32'd7, 32'd2, 1'b0, 1'b0, 33);
    add_vec(4'b1100, 32'd5, 32'd0, 32'hFFFFFFFF, 1'b0, 1'b0, 33);
    add_vec(4'b1101, 32'd5, 32'd0, 32'd5, 1'b0, 1'b0, 33);
    add_vec(4'b1110, 32'd5, 32'd1, 32'd0, 1'b1, 1'b1, 1);
`else
    add_vec(4'b1100, 32'd100, 32'd7, 32'd0, 1'b1, 1'b1, 1);
    add_vec(4'b1101, 32'd100, 32'd7, 32'd0, 1'b1, 1'b1, 1);
`endif

    // Reset state
    rst = 1'b1; start = 1'b0; ALUOp = 4'd0; R2 = 32'd0; R3 = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_r1", R1, 32'd0);
    check("rst_zero", {31'd0, Zero}, 32'd1);
    check("rst_illegal", {31'd0, Illegal}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < vecs.size(); i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, z, il, lat);
      check($sformatf("vec%0d_r1", i), res, vecs[i].exp);
      check($sformatf("vec%0d_zero", i), {31'd0, z}, {31'd0, vecs[i].ez});
      check($sformatf("vec%0d_illegal", i), {31'd0, il}, {31'd0, vecs[i].eil});
      check($sformatf("vec%0d_latency", i), lat, elat_of(i));
    end

    // MUL timing: busy/done per cycle, start ignored in EXEC and FIN, operands latched
    @(negedge clk);
    ALUOp = 4'b1011; R2 = 32'h00010001; R3 = 32'h00010001; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 33; c++) begin
      check($sformatf("mul_busy_c%0d", c), {31'd0, busy}, (c <= 32) ? 32'd1 : 32'd0);
      check($sformatf("mul_done_c%0d", c), {31'd0, done}, (c == 33) ? 32'd1 : 32'd0);
      if (c == 5) begin
        start = 1'b1; ALUOp = 4'b0010; R2 = 32'h0000FFFF; R3 = 32'h00000003;
      end
      if (c == 6) begin
        start = 1'b0;
      end
      if (c == 33) begin
        check("mul_r1", R1, 32'h00020001);
        start = 1'b1; ALUOp = 4'b0010; R2 = 32'd1; R3 = 32'd1;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("fin_start_ignored_done%0d", c), {31'd0, done}, 32'd0);
      check($sformatf("fin_start_ignored_r1_%0d", c), R1, 32'h00020001);
      @(posedge clk); #1;
    end

    // Reset in cycle 10 of a MUL
    @(negedge clk);
    ALUOp = 4'b1011; R2 = 32'd3; R3 = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_r1", R1, 32'd0);
    check("midrst_zero", {31'd0, Zero}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    check("midrst_no_done", pulses, 32'd0);
    run_op(4'b0010, 32'd5, 32'd7, res, z, il, lat);
    check("post_rst_add_r1", res, 32'd12);
    check("post_rst_add_latency", lat, 32'd1);

    // Randomized ops against the reference model
    for (int n = 0; n < 30; n++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 15));
      ea = $urandom();
      eb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom();
      ref_op(op, ea, eb, eres, eil, elat);
      run_op(op, ea, eb, res, z, il, lat);
      check($sformatf("rnd%0d_op%0d_r1", n, op), res, eres);
      check($sformatf("rnd%0d_op%0d_zero", n, op), {31'd0, z}, (eres == 32'd0) ? 32'd1 : 32'd0);
      check($sformatf("rnd%0d_op%0d_illegal", n, op), {31'd0, il}, {31'd0, eil});
      check($sformatf("rnd%0d_op%0d_latency", n, op), lat, elat);
    end

    r1_hold = R1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  function automatic int elat_of(input int i);
    return vecs[i].elat;
  endfunction

endmodule
